// File: rtl/mux_arbiter_if.sv
// rtl/mux_arbiter_if.sv - two-producer / one-consumer handshake bundle for mux_arbiter
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             out_ready;
    logic             busy;

    // Arbiter side
    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last, out_src, busy,
        input  out_ready
    );

    // Producer/consumer side
    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last, out_src, busy,
        output out_ready
    );
endinterface

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin burst arbiter feeding a registered 2:1 data mux
module mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             out_src_q;

    logic             load_en;
    logic             ready0, ready1;
    logic             sel;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign load_en  = rst_n && (!out_valid_q || bus.out_ready);
    assign sel_data = sel ? bus.in1_data : bus.in0_data;
    assign sel_last = sel ? bus.in1_last : bus.in0_last;

    // Grant selection, ready generation and next-state/priority update
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ready0       = 1'b0;
        ready1       = 1'b0;
        sel          = 1'b0;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in0_valid && (!bus.in1_valid || last_grant_q)) begin
                    sel    = 1'b0;
                    ready0 = load_en;
                    accept = load_en;
                end else if (bus.in1_valid) begin
                    sel    = 1'b1;
                    ready1 = load_en;
                    accept = load_en;
                end
                if (accept) begin
                    if (sel_last) begin
                        last_grant_d = sel;
                    end else begin
                        state_d = sel ? LOCK1 : LOCK0;
                    end
                end
            end
            LOCK0: begin
                sel    = 1'b0;
                ready0 = load_en;
                accept = load_en && bus.in0_valid;
                if (accept && bus.in0_last) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            LOCK1: begin
                sel    = 1'b1;
                ready1 = load_en;
                accept = load_en && bus.in1_valid;
                if (accept && bus.in1_last) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state; last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output stage: load on accept, drain on out_ready, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
            out_src_q   <= sel;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in0_ready = ready0;
    assign bus.in1_ready = ready1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and sequencer for a two-input, WIDTH-bit 2:1 data multiplexer. Two requesters present bursts over valid/ready handshakes, and the block selects one of them. The selected beats pass through a single registered output stage. A burst, terminated by `inX_last`, is never interleaved with the other requester's beats. The block sits between two producer ports and one shared consumer, and exports the active select as `out_src`.

## Interface
- `WIDTH`, default 8: data width of each input and of the output.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in0_valid`  input  1  requester 0 has a beat.
- `in0_data`  input  WIDTH  requester 0 data.
- `in0_last`  input  1  requester 0 beat is the final beat of its burst.
- `in0_ready`  output  1  requester 0 beat accepted this cycle.
- `in1_valid`, `in1_data`, `in1_last`, `in1_ready`: same as port 0, for requester 1.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  registered muxed data.
- `out_last`  output  1  registered copy of the accepted beat's last flag.
- `out_src`  output  1  source index of the beat in the output register (0 = din_0 side, 1 = din_1 side).
- `out_ready`  input  1  consumer accepts the output beat.
- `busy`  output  1  a multi-beat burst is in progress (state is not IDLE).

## Operation
- `load_en = !out_valid || out_ready`: the output register may be loaded this cycle.
- State machine states:
  - IDLE: no port holds a grant.
  - LOCK0: port 0 holds the grant.
  - LOCK1: port 1 holds the grant.
- Priority pointer `last_grant` (1 bit) records which port completed the most recent burst.
- IDLE arbitration, evaluated combinationally:
  - Only one valid: that port wins.
  - Both valid: the port `!last_grant` wins.
  - Winner's ready = `load_en`. Loser's ready = 0.
- Accepted beat in IDLE:
  - `last = 1`: stay IDLE and set `last_grant` to the winner.
  - `last = 0`: go to LOCKx for the winner.
- LOCKx:
  - `inx_ready = load_en`. The other port's ready = 0, even if it is valid.
  - Accepted beat with `last = 1`: go to IDLE and set `last_grant = x`.
  - `inx_valid` low inside a burst: hold LOCKx indefinitely. The other port stays blocked.
- Output register:
  - Accept (`inX_valid && inX_ready`): load `out_data`/`out_last` from the selected port, set `out_src = X`, set `out_valid = 1`.
  - `out_ready` with no accept: clear `out_valid`.
  - Otherwise hold all output fields.
- `out_data`, `out_last` and `out_src` change only on an accept.
- Ready never depends on `out_valid` being low alone; a simultaneous drain and load is one cycle.
- `busy = (state != IDLE)`.

## Timing
- Reset values while `rst_n` is low, applied asynchronously:
  - state IDLE, `last_grant = 1` (port 0 wins the first tie).
  - `out_valid = 0`, `out_data = 0`, `out_last = 0`, `out_src = 0`, `busy = 0`.
  - `in0_ready = 0`, `in1_ready = 0`.
- Reset released mid-burst: the burst is abandoned and the block restarts at IDLE. The partial burst is not resumed.
- Latency: an input beat accepted at edge N appears on `out_*` with `out_valid = 1` after edge N.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Backpressure: with `out_valid = 1` and `out_ready = 0`, both readies are 0 and the output fields are stable.
- Grant switch: the last beat of a burst from port X and the first beat from port Y on the following cycle is allowed, with no bubble.
- `out_ready` while `out_valid = 0` has no effect.
- Input valid dropping mid-burst only inserts bubbles; the lock is released solely by an accepted beat with `last = 1`.

## Test plan
- Reset, then `in0` single beat 0xA5 with last=1 and `out_ready=1` -> `in0_ready=1` in that cycle; next cycle `out_valid=1`, `out_data=0xA5`, `out_src=0`, `busy=0`.
- Both ports request continuously, every beat with last=1, `out_ready=1` -> `out_src` alternates 0,1,0,1 starting with 0; one beat per cycle.
- Port 1 sends a 3-beat burst 0x11, 0x22, 0x33 (last on 0x33) while port 0 is valid throughout -> `in0_ready=0` for all three beats; output shows 0x11, 0x22, 0x33 with `out_src=1`; port 0 is granted on the cycle after 0x33 is accepted.
- `out_ready=0` for 4 cycles with `out_valid=1` -> both readies 0; `out_data`, `out_src`, `out_last` unchanged; the beat is delivered after `out_ready` rises.
- `in0` burst stalls, with `in0_valid` low for 2 cycles mid-burst while `in1_valid=1` -> `busy=1`; `in1_ready=0` throughout; `in0` resumes and completes the burst.
- `rst_n` asserted in LOCK0 with `out_valid=1` -> immediately `out_valid=0` and `busy=0`; after release, a tie is granted to port 0.
